// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite read master.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // Stale-beat counter increment.
  // It saturates at 3: once three beats are owed, no further commands are taken.
  function automatic logic [1:0] stale_inc(input logic [1:0] stale);
    return (stale == 2'd3) ? stale : stale + 2'd1;
  endfunction

endpackage

// File: rtl/axi4_lite_watchdog.sv
// R-phase watchdog.
// The counter is cleared to zero and counts while enabled. expired_o flags the
// cycle in which the count sits at TIMEOUT-1. The count holds at that terminal
// value, so a discarded stale beat that lands on the terminal cycle only delays
// the timeout by one cycle. A TIMEOUT of 0 never expires.
module axi4_lite_watchdog #(
  parameter int  TIMEOUT = 255,
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk_i,
  input  logic rst_clk_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TW-1:0] TC_VAL = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [TW-1:0] count;
  logic          at_tc;

  assign at_tc     = (TIMEOUT != 0) && (count == TC_VAL);
  assign expired_o = enable_i && at_tc;

  // Counter: clear has priority, then count up until the terminal value.
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (enable_i && !at_tc) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite single-word read master.
// One command is turned into an AR handshake and an R handshake. The result is
// returned on the rsp port. Beats that belong to reads that timed out earlier
// are counted in "stale" and discarded as they arrive.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a command (blocked while 3 stale beats are owed)
// ADDR  | AR valid asserted, holding address until AR ready
// DATA  | R ready asserted, watchdog running, dropping stale beats
// RESP  | result valid, holding until rsp_ready_i
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int  DEPTH     = 8,
  parameter int  DATA_SIZE = 32,
  parameter int  TIMEOUT   = 255,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_clk_ni,
  input  logic [AW-1:0]        cmd_address_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic [AW-1:0]        read_address_o,
  output logic                 read_address_valid_o,
  input  logic                 read_address_ready_i,
  input  logic [DATA_SIZE-1:0] read_data_i,
  input  logic [1:0]           read_data_response_i,
  input  logic                 read_data_valid_i,
  output logic                 read_data_ready_o,
  output logic [DATA_SIZE-1:0] rsp_data_o,
  output logic [1:0]           rsp_response_o,
  output logic                 rsp_timeout_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i
);

  state_t               state, state_next;
  logic [1:0]           stale, stale_next;
  logic [AW-1:0]        addr_next;
  logic [DATA_SIZE-1:0] data_next;
  logic [1:0]           resp_next;
  logic                 timeout_next;

  logic cmd_hs, ar_hs, r_hs, rsp_hs;
  logic wd_expired;

  assign cmd_hs = cmd_valid_i && cmd_ready_o;
  assign ar_hs  = read_address_valid_o && read_address_ready_i;
  assign r_hs   = read_data_valid_i && read_data_ready_o;
  assign rsp_hs = rsp_valid_o && rsp_ready_i;

  axi4_lite_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_clk_ni(rst_clk_ni),
    .clear_i   (ar_hs),
    .enable_i  (state == DATA),
    .expired_o (wd_expired)
  );

  // Next-state, stale bookkeeping and next values of the result registers.
  always_comb begin
    state_next   = state;
    stale_next   = stale;
    addr_next    = read_address_o;
    data_next    = rsp_data_o;
    resp_next    = rsp_response_o;
    timeout_next = rsp_timeout_o;

    // A beat that arrives while stale beats are still owed is the oldest
    // outstanding one (AXI keeps R in order), so it is dropped here in any state.
    if (r_hs && (stale != 2'd0)) begin
      stale_next = stale - 2'd1;
    end

    case (state)
      IDLE: begin
        if (cmd_hs) begin
          addr_next  = cmd_address_i;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (r_hs && (stale == 2'd0)) begin
          data_next    = read_data_i;
          resp_next    = read_data_response_i;
          timeout_next = 1'b0;
          state_next   = RESP;
        end else if (wd_expired && !r_hs) begin
          data_next    = '0;
          resp_next    = RESP_SLVERR;
          timeout_next = 1'b1;
          stale_next   = stale_inc(stale);
          state_next   = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and stale counter registers.
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state <= IDLE;
      stale <= 2'd0;
    end else begin
      state <= state_next;
      stale <= stale_next;
    end
  end

  // Registered outputs.
  // The handshake outputs are derived from the next state so they line up
  // with it. R ready also stays high whenever stale beats are still owed.
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      cmd_ready_o          <= 1'b0;
      read_address_o       <= '0;
      read_address_valid_o <= 1'b0;
      read_data_ready_o    <= 1'b0;
      rsp_data_o           <= '0;
      rsp_response_o       <= 2'd0;
      rsp_timeout_o        <= 1'b0;
      rsp_valid_o          <= 1'b0;
    end else begin
      cmd_ready_o          <= (state_next == IDLE) && (stale_next != 2'd3);
      read_address_o       <= addr_next;
      read_address_valid_o <= (state_next == ADDR);
      read_data_ready_o    <= (state_next == DATA) || (stale_next != 2'd0);
      rsp_data_o           <= data_next;
      rsp_response_o       <= resp_next;
      rsp_timeout_o        <= timeout_next;
      rsp_valid_o          <= (state_next == RESP);
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Testbench for axi4_lite_read_master.
// The main instance uses TIMEOUT=16 and is checked through AR and result
// scoreboards. A second instance with TIMEOUT=0 checks that the watchdog can
// be disabled.
module tb_axi4_lite_read_master;
  import axi4_lite_pkg::*;

  localparam int AW = 3;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] cmd_address;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] read_address;
  logic          ar_valid, ar_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_valid, r_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_response;
  logic          rsp_timeout, rsp_valid, rsp_ready;

  logic [AW-1:0] n_cmd_address;
  logic          n_cmd_valid, n_cmd_ready;
  logic [AW-1:0] n_read_address;
  logic          n_ar_valid, n_ar_ready;
  logic [DW-1:0] n_r_data;
  logic [1:0]    n_r_resp;
  logic          n_r_valid, n_r_ready;
  logic [DW-1:0] n_rsp_data;
  logic [1:0]    n_rsp_response;
  logic          n_rsp_timeout, n_rsp_valid, n_rsp_ready;

  axi4_lite_read_master #(.DEPTH(8), .DATA_SIZE(DW), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_clk_ni(rst_n),
    .cmd_address_i(cmd_address), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .read_address_o(read_address), .read_address_valid_o(ar_valid),
    .read_address_ready_i(ar_ready),
    .read_data_i(r_data), .read_data_response_i(r_resp),
    .read_data_valid_i(r_valid), .read_data_ready_o(r_ready),
    .rsp_data_o(rsp_data), .rsp_response_o(rsp_response), .rsp_timeout_o(rsp_timeout),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready)
  );

  axi4_lite_read_master #(.DEPTH(8), .DATA_SIZE(DW), .TIMEOUT(0)) dut_nt (
    .clk_i(clk), .rst_clk_ni(rst_n),
    .cmd_address_i(n_cmd_address), .cmd_valid_i(n_cmd_valid), .cmd_ready_o(n_cmd_ready),
    .read_address_o(n_read_address), .read_address_valid_o(n_ar_valid),
    .read_address_ready_i(n_ar_ready),
    .read_data_i(n_r_data), .read_data_response_i(n_r_resp),
    .read_data_valid_i(n_r_valid), .read_data_ready_o(n_r_ready),
    .rsp_data_o(n_rsp_data), .rsp_response_o(n_rsp_response), .rsp_timeout_o(n_rsp_timeout),
    .rsp_valid_o(n_rsp_valid), .rsp_ready_i(n_rsp_ready)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          tmo;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [AW-1:0] ar_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [1:0] r, input logic t);
    rsp_t e;
    e.data = d;
    e.resp = r;
    e.tmo  = t;
    ar_q.push_back(a);
    rsp_q.push_back(e);
  endtask

  // Monitor: compare AR addresses and results against the scoreboards on each handshake.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst_n && ar_valid && ar_ready) begin
      if (ar_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL ar_unexpected: got address %0d, expected no AR", read_address);
      end else begin
        check("ar_addr", 64'(read_address), 64'(ar_q.pop_front()));
      end
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected: got data 0x%0h, expected no result", rsp_data);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_response", 64'(rsp_response), 64'(e.resp));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a);
    int n = 0;
    cmd_address = a;
    cmd_valid   = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) check("cmd_accept_wait", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ar_accept(input int hold);
    int n = 0;
    int bad = 0;
    logic [AW-1:0] a0;
    while (!ar_valid && n < 100) begin tick(); n++; end
    if (!ar_valid) check("ar_valid_wait", 64'(ar_valid), 64'd1);
    a0 = read_address;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (ar_valid !== 1'b1 || read_address !== a0) bad++;
    end
    if (hold > 0) check("ar_hold_stable", 64'(bad), 64'd0);
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
  endtask

  task automatic r_beat(input logic [DW-1:0] d, input logic [1:0] rs, input int dly);
    int n = 0;
    repeat (dly) tick();
    r_data  = d;
    r_resp  = rs;
    r_valid = 1'b1;
    while (!r_ready && n < 100) begin tick(); n++; end
    if (!r_ready) check("r_ready_wait", 64'(r_ready), 64'd1);
    tick();
    r_valid = 1'b0;
    r_data  = '0;
    r_resp  = 2'd0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (rsp_q.size() != 0 && n < 100) begin tick(); n++; end
    check("result_drained", 64'(rsp_q.size()), 64'd0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 2000) begin tick(); n++; end
  endtask

  initial begin : global_guard
    #300000;
    fails++;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "simulation aborted");
  end

  initial begin : stimulus
    int n;
    int bad;
    cmd_address = '0; cmd_valid = 1'b0; ar_ready = 1'b0;
    r_data = '0; r_resp = 2'd0; r_valid = 1'b0; rsp_ready = 1'b1;
    n_cmd_address = '0; n_cmd_valid = 1'b0; n_ar_ready = 1'b1;
    n_r_data = '0; n_r_resp = 2'd0; n_r_valid = 1'b0; n_rsp_ready = 1'b1;

    // Reset
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs", 64'({cmd_ready, ar_valid, read_address, r_ready, rsp_data,
                                rsp_response, rsp_timeout, rsp_valid}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // Basic read of register 3
    expect_read(3, 32'hDEADBEEF, RESP_OKAY, 1'b0);
    send_cmd(3); ar_accept(0); r_beat(32'hDEADBEEF, RESP_OKAY, 0); wait_done();

    // AR backpressure for 10 cycles
    expect_read(6, 32'h0606_0606, RESP_OKAY, 1'b0);
    send_cmd(6); ar_accept(10); r_beat(32'h0606_0606, RESP_OKAY, 2); wait_done();

    // Result backpressure for 5 cycles, EXOKAY passed through
    expect_read(2, 32'h2222_2222, RESP_EXOKAY, 1'b0);
    rsp_ready = 1'b0;
    send_cmd(2); ar_accept(0); r_beat(32'h2222_2222, RESP_EXOKAY, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h2222_2222 || cmd_ready !== 1'b0) bad++;
      tick();
    end
    check("rsp_hold_stable", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    wait_done();

    // DECERR passed through
    expect_read(4, 32'h0000_1234, RESP_DECERR, 1'b0);
    send_cmd(4); ar_accept(1); r_beat(32'h0000_1234, RESP_DECERR, 0); wait_done();

    // Watchdog timeout, 16 cycles after entering DATA
    expect_read(7, 32'h0, RESP_SLVERR, 1'b1);
    send_cmd(7); ar_accept(0); wait_rsp(n);
    check("timeout_latency", 64'(n), 64'd16);
    wait_done();
    check("r_ready_held_stale", 64'(r_ready), 64'd1);

    // Stale beat discarded, second beat is the result
    expect_read(5, 32'h0000_5555, RESP_OKAY, 1'b0);
    send_cmd(5); ar_accept(0);
    r_beat(32'h0000_AAAA, RESP_OKAY, 0); r_beat(32'h0000_5555, RESP_OKAY, 0);
    wait_done();
    check("r_ready_released", 64'(r_ready), 64'd0);

    // R handshake on the terminal cycle wins over the timeout
    expect_read(1, 32'h0F0F_0F0F, RESP_OKAY, 1'b0);
    send_cmd(1); ar_accept(0); r_beat(32'h0F0F_0F0F, RESP_OKAY, 15); wait_done();

    // Three timeouts saturate stale; commands are blocked until one beat drains
    for (int i = 0; i < 3; i++) begin
      expect_read(0, 32'h0, RESP_SLVERR, 1'b1);
      send_cmd(0); ar_accept(0); wait_done();
    end
    cmd_address = 3'd5;
    cmd_valid   = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready !== 1'b0) bad++;
      tick();
    end
    cmd_valid = 1'b0;
    check("sat_cmd_ready_low", 64'(bad), 64'd0);
    r_beat(32'hBAD0_0001, RESP_OKAY, 0);
    check("sat_cmd_ready_after_drain", 64'(cmd_ready), 64'd1);
    expect_read(2, 32'h7777_7777, RESP_OKAY, 1'b0);
    send_cmd(2); ar_accept(0);
    r_beat(32'hBAD0_0002, RESP_OKAY, 0); r_beat(32'hBAD0_0003, RESP_OKAY, 0);
    r_beat(32'h7777_7777, RESP_OKAY, 0);
    wait_done();
    check("sat_stale_empty", 64'(r_ready), 64'd0);

    // Reset mid-DATA while a stale beat is owed
    expect_read(0, 32'h0, RESP_SLVERR, 1'b1);
    send_cmd(0); ar_accept(0); wait_done();
    ar_q.push_back(3'd6);
    send_cmd(6); ar_accept(0); tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    check("reset_async_outputs", 64'({cmd_ready, ar_valid, read_address, r_ready, rsp_data,
                                      rsp_response, rsp_timeout, rsp_valid}), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("cmd_ready_after_reset2", 64'(cmd_ready), 64'd1);
    check("stale_cleared", 64'(r_ready), 64'd0);
    expect_read(5, 32'h1357_9BDF, RESP_OKAY, 1'b0);
    send_cmd(5); ar_accept(0); r_beat(32'h1357_9BDF, RESP_OKAY, 0); wait_done();

    // TIMEOUT=0 instance: no timeout in 1000 cycles
    n_cmd_address = 3'd2;
    n_cmd_valid   = 1'b1;
    n = 0;
    while (!n_cmd_ready && n < 100) begin tick(); n++; end
    tick();
    n_cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (n_rsp_valid !== 1'b0) bad++;
    end
    check("nt_no_timeout", 64'(bad), 64'd0);
    check("nt_waiting_in_data", 64'(n_r_ready), 64'd1);
    n_r_data  = 32'hCAFE_F00D;
    n_r_resp  = RESP_OKAY;
    n_r_valid = 1'b1;
    tick();
    n_r_valid = 1'b0;
    check("nt_rsp_valid", 64'(n_rsp_valid), 64'd1);
    check("nt_rsp_data", 64'(n_rsp_data), 64'hCAFE_F00D);
    check("nt_rsp_timeout", 64'(n_rsp_timeout), 64'd0);
    tick();

    check("ar_queue_empty", 64'(ar_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
